// File: rtl/gin_scatter_bus_pkg.sv
// Shared sizing defaults for the GIN scatter bus slice and the word/ID types built from them.
// The guards defer to any project-wide definition of these defines.
`ifndef DATA_BITS
`define DATA_BITS 16
`endif
`ifndef XID_BITS
`define XID_BITS 4
`endif
`ifndef NUMS_PE_COL
`define NUMS_PE_COL 4
`endif

package gin_scatter_bus_pkg;
  typedef logic [`XID_BITS-1:0]  xid_t;
  typedef logic [`DATA_BITS-1:0] word_t;
endpackage

// File: rtl/gin_id_match.sv
// One slave's scan-loaded ID register plus its tag comparator.
module gin_id_match
  import gin_scatter_bus_pkg::*;
#(
  parameter int ID_SIZE = `XID_BITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               set_id,
  input  logic [ID_SIZE-1:0] scan_in,
  input  logic [ID_SIZE-1:0] tag,
  output logic               match,
  output logic [ID_SIZE-1:0] scan_out
);

  logic [ID_SIZE-1:0] id;

  // NOTE: state registers use non-blocking assignments so every stage of the
  // scan chain samples its neighbour's pre-edge value and the chain shifts by one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id <= '0;
    end else if (set_id) begin
      id <= scan_in;
    end
  end

  assign match    = (tag == id);
  assign scan_out = id;

endmodule

// File: rtl/gin_scatter_bus.sv
// Single-master multicast bus: holds one tagged word until every slave whose ID matches has taken it.
module gin_scatter_bus
  import gin_scatter_bus_pkg::*;
#(
  parameter int NUMS_SLAVE = `NUMS_PE_COL,
  parameter int ID_SIZE    = `XID_BITS,
  parameter int DATA_BITS  = `DATA_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_SIZE-1:0]    tag,
  input  logic                  master_valid,
  input  logic [DATA_BITS-1:0]  master_data,
  output logic                  master_ready,
  output logic [NUMS_SLAVE-1:0] slave_valid,
  output logic [DATA_BITS-1:0]  slave_data,
  input  logic [NUMS_SLAVE-1:0] slave_ready,
  input  logic                  set_id,
  input  logic [ID_SIZE-1:0]    ID_scan_in,
  output logic [ID_SIZE-1:0]    ID_scan_out
);

  logic                  full;
  logic [DATA_BITS-1:0]  data_q;
  logic [NUMS_SLAVE-1:0] pending;
  logic [NUMS_SLAVE-1:0] match;
  logic [ID_SIZE-1:0]    id_chain [NUMS_SLAVE+1];
  logic                  done_now;
  logic                  accept;

  assign id_chain[0] = ID_scan_in;

  for (genvar i = 0; i < NUMS_SLAVE; i++) begin : g_slave
    gin_id_match #(.ID_SIZE(ID_SIZE)) u_id_match (
      .clk     (clk),
      .rst     (rst),
      .set_id  (set_id),
      .scan_in (id_chain[i]),
      .tag     (tag),
      .match   (match[i]),
      .scan_out(id_chain[i+1])
    );
  end

  assign ID_scan_out = id_chain[NUMS_SLAVE];

  // The last outstanding slave accepting frees the buffer in the same cycle,
  // so master_ready looks straight through slave_ready for full throughput.
  assign done_now     = full && ((pending & ~slave_ready) == '0);
  assign master_ready = !full || done_now;
  assign accept       = master_valid && master_ready;

  // NOTE: data_q is a plain register, not a memory, so it is cleared on reset
  // to keep slave_data deterministic out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full    <= 1'b0;
      data_q  <= '0;
      pending <= '0;
    end else if (accept) begin
      data_q  <= master_data;
      pending <= match;
      full    <= (match != '0);
    end else if (full) begin
      pending <= pending & ~slave_ready;
      if (done_now) begin
        full <= 1'b0;
      end
    end
  end

  assign slave_valid = full ? pending : '0;
  assign slave_data  = data_q;

endmodule

// File: tb/tb_gin_scatter_bus.sv
// Self-checking bench for gin_scatter_bus: directed test-plan scenarios, then randomized traffic vs a queue-based model.
module tb_gin_scatter_bus;
  import gin_scatter_bus_pkg::*;

  localparam int NS = 4;
  localparam int IW = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [IW-1:0] tag = '0;
  logic          master_valid = 1'b0;
  logic [DW-1:0] master_data = '0;
  logic          master_ready;
  logic [NS-1:0] slave_valid;
  logic [DW-1:0] slave_data;
  logic [NS-1:0] slave_ready = '0;
  logic          set_id = 1'b0;
  logic [IW-1:0] ID_scan_in = '0;
  logic [IW-1:0] ID_scan_out;

  int tests = 0;
  int fails = 0;
  bit checking = 1'b0;

  gin_scatter_bus #(.NUMS_SLAVE(NS), .ID_SIZE(IW), .DATA_BITS(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .tag         (tag),
    .master_valid(master_valid),
    .master_data (master_data),
    .master_ready(master_ready),
    .slave_valid (slave_valid),
    .slave_data  (slave_data),
    .slave_ready (slave_ready),
    .set_id      (set_id),
    .ID_scan_in  (ID_scan_in),
    .ID_scan_out (ID_scan_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the list of slaves still owed the held word, plus the ID table.
  int    m_id [NS];
  int    owed [$];
  word_t m_word;

  function automatic logic [NS-1:0] exp_valid();
    logic [NS-1:0] v = '0;
    foreach (owed[k]) v[owed[k]] = 1'b1;
    return v;
  endfunction

  function automatic logic exp_ready();
    foreach (owed[k]) if (!slave_ready[owed[k]]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    int keep [$];
    if (!rst) begin
      owed.delete();
      m_word = '0;
      foreach (m_id[s]) m_id[s] = 0;
    end else begin
      if (master_valid && exp_ready()) begin
        m_word = master_data;
        owed.delete();
        for (int s = 0; s < NS; s++) if (m_id[s] == int'(tag)) owed.push_back(s);
      end else begin
        keep.delete();
        foreach (owed[k]) if (!slave_ready[owed[k]]) keep.push_back(owed[k]);
        owed = keep;
      end
      if (set_id) begin
        for (int s = NS - 1; s > 0; s--) m_id[s] = m_id[s-1];
        m_id[0] = int'(ID_scan_in);
      end
    end
  end

  always @(negedge clk) begin
    if (checking) begin
      check("master_ready", {31'b0, master_ready}, {31'b0, exp_ready()});
      check("slave_valid", {28'b0, slave_valid}, {28'b0, exp_valid()});
      check("ID_scan_out", {28'b0, ID_scan_out}, {28'b0, 4'(m_id[NS-1])});
      if (owed.size() != 0) check("slave_data", {16'b0, slave_data}, {16'b0, m_word});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shift in IDs so that slave s ends up with ids[s]; last slave goes in first.
  task automatic load_ids(input int i0, input int i1, input int i2, input int i3);
    int seq [4];
    seq = '{i3, i2, i1, i0};
    for (int k = 0; k < 4; k++) begin
      set_id = 1'b1;
      ID_scan_in = 4'(seq[k]);
      tick();
    end
    set_id = 1'b0;
  endtask

  task automatic send(input int t, input logic [DW-1:0] d);
    master_valid = 1'b1;
    tag = 4'(t);
    master_data = d;
    tick();
    master_valid = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    check("reset_master_ready", {31'b0, master_ready}, 32'd1);
    check("reset_slave_valid", {28'b0, slave_valid}, 32'd0);
    check("reset_slave_data", {16'b0, slave_data}, 32'd0);
    check("reset_scan_out", {28'b0, ID_scan_out}, 32'd0);
    rst = 1'b1;
    checking = 1'b1;
    tick();

    // Scan configuration
    load_ids(0, 1, 2, 3);
    check("scan_out_after_4", {28'b0, ID_scan_out}, 32'd3);
    for (int s = 0; s < NS; s++) check("model_id", m_id[s], s);

    // Unicast
    send(2, 16'hBEEF);
    check("uni_valid", {28'b0, slave_valid}, 32'b0100);
    check("uni_data", {16'b0, slave_data}, 32'hBEEF);
    check("uni_busy", {31'b0, master_ready}, 32'd0);
    slave_ready = 4'b0100;
    #1;
    check("uni_retire_ready", {31'b0, master_ready}, 32'd1);
    tick();
    slave_ready = '0;
    check("uni_done", {28'b0, slave_valid}, 32'd0);

    // Multicast with partial accept
    load_ids(5, 5, 7, 5);
    send(5, 16'h1234);
    check("mc_valid", {28'b0, slave_valid}, 32'b1011);
    slave_ready = 4'b0001;
    #1;
    check("mc_busy1", {31'b0, master_ready}, 32'd0);
    tick();
    check("mc_partial", {28'b0, slave_valid}, 32'b1010);
    slave_ready = 4'b1010;
    #1;
    check("mc_retire_ready", {31'b0, master_ready}, 32'd1);
    tick();
    slave_ready = '0;
    check("mc_done", {28'b0, slave_valid}, 32'd0);

    // Zero match
    load_ids(0, 1, 2, 3);
    send(9, 16'h0F0F);
    check("zm_valid", {28'b0, slave_valid}, 32'd0);
    check("zm_ready", {31'b0, master_ready}, 32'd1);

    // Full throughput
    slave_ready = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      master_valid = 1'b1;
      tag = 4'd1;
      master_data = 16'hA000 + 16'(i);
      tick();
      check("tp_valid", {28'b0, slave_valid}, 32'b0010);
      check("tp_data", {16'b0, slave_data}, 32'hA000 + i);
    end
    master_valid = 1'b0;
    tick();
    slave_ready = '0;

    // Reset mid-delivery
    load_ids(0, 6, 6, 3);
    send(6, 16'h7777);
    check("rst_pre_valid", {28'b0, slave_valid}, 32'b0110);
    rst = 1'b0;
    #1;
    check("rst_valid", {28'b0, slave_valid}, 32'd0);
    check("rst_ready", {31'b0, master_ready}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check("rst_scan_out", {28'b0, ID_scan_out}, 32'd0);
    send(0, 16'h5A5A);
    check("rst_bcast_valid", {28'b0, slave_valid}, 32'b1111);
    check("rst_bcast_data", {16'b0, slave_data}, 32'h5A5A);
    slave_ready = 4'b1111;
    tick();
    slave_ready = '0;

    // Randomized traffic against the model
    load_ids(1, 2, 1, 3);
    for (int c = 0; c < 3000; c++) begin
      master_valid = ($urandom_range(0, 3) != 0);
      tag          = 4'($urandom_range(0, 4));
      master_data  = 16'($urandom);
      slave_ready  = 4'($urandom);
      set_id       = ($urandom_range(0, 15) == 0);
      ID_scan_in   = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
      end else begin
        tick();
      end
    end
    master_valid = 1'b0;
    set_id = 1'b0;
    slave_ready = '0;
    tick();
    checking = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
